// File: rtl/spi_bus_scheduler.sv
// spi_bus_scheduler: round-robin sharing of one SPI controller among NUM_REQ requesters
module spi_bus_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int LEN_W    = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*LEN_W-1:0] i_len,
    input  logic [NUM_REQ*11-1:0]    i_cfg,
    output logic [NUM_REQ-1:0]       o_grant,
    input  logic [7:0]               i_wdata,
    input  logic                     i_wvalid,
    output logic                     o_wready,
    output logic [7:0]               o_rdata,
    output logic                     o_rvalid,
    output logic                     o_done,
    output logic                     o_err,
    output logic [NUM_REQ-1:0]       o_cs_n,
    output logic [10:0]              o_spi_config,
    output logic [7:0]               o_spi_tx,
    output logic                     o_spi_tx_valid,
    input  logic [7:0]               i_spi_rx,
    input  logic                     i_spi_rx_valid,
    input  logic                     i_spi_ready
);
    localparam int PW        = $clog2(NUM_REQ);
    localparam int TW        = $clog2(TIMEOUT + CS_SETUP + CS_HOLD + 1);
    localparam int SETUP_END = (CS_SETUP > 1) ? CS_SETUP - 2 : 0;

    typedef enum logic [2:0] {IDLE, ARB, SETUP, FETCH, SEND, RECV, HOLD, DONE} state_t;

    state_t               r_state, w_next;
    logic [PW-1:0]        r_ptr, r_idx, w_win, w_j;
    logic [NUM_REQ-1:0]   r_grant, r_cs_n;
    logic [LEN_W-1:0]     r_cnt, w_len;
    logic [10:0]          r_cfg;
    logic [7:0]           r_tx, r_rdata;
    logic                 r_tx_valid, r_rvalid, r_wready, r_err;
    logic [TW-1:0]        r_tcnt;
    logic                 w_accept, w_tmo;
    logic [LEN_W-1:0]     w_lens [NUM_REQ];
    logic [10:0]          w_cfgs [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_lens[g] = i_len[g*LEN_W +: LEN_W];
        assign w_cfgs[g] = i_cfg[g*11 +: 11];
    end

    assign w_len    = w_lens[r_idx];
    assign w_accept = (r_state == FETCH) && i_wvalid && i_spi_ready;
    // Timeout only fires when the awaited handshake has not arrived this cycle.
    assign w_tmo    = (r_tcnt == TW'(TIMEOUT - 1)) &&
                      (((r_state == SEND) && i_spi_ready) || ((r_state == RECV) && !i_spi_rx_valid));

    // Lowest wrap distance from the pointer wins: later (nearer) iterations override.
    always_comb begin
        w_win = r_ptr;
        w_j   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_j = PW'((int'(r_ptr) + i) % NUM_REQ);
            if (i_req[w_j]) w_win = w_j;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = (|i_req) ? ARB : IDLE;
            ARB:   w_next = (w_len == '0) ? DONE : SETUP;
            SETUP: w_next = (r_tcnt == TW'(SETUP_END)) ? FETCH : SETUP;
            FETCH: w_next = w_accept ? SEND : FETCH;
            SEND:  w_next = !i_spi_ready ? RECV : (w_tmo ? HOLD : SEND);
            RECV:  w_next = i_spi_rx_valid ? ((r_cnt == LEN_W'(1)) ? HOLD : FETCH) : (w_tmo ? HOLD : RECV);
            HOLD:  w_next = (r_tcnt == TW'(CS_HOLD - 1)) ? DONE : HOLD;
            DONE:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ptr      <= PW'(NUM_REQ - 1);
            r_idx      <= '0;
            r_grant    <= '0;
            r_cs_n     <= '1;
            r_cnt      <= '0;
            r_cfg      <= '0;
            r_tx       <= '0;
            r_tx_valid <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_wready   <= 1'b0;
            r_err      <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_tcnt   <= (w_next != r_state) ? '0 : r_tcnt + 1'b1;
            r_rvalid <= 1'b0;
            r_wready <= w_accept;
            case (r_state)
                IDLE: if (|i_req) begin
                    r_grant <= NUM_REQ'(1) << w_win;
                    r_idx   <= w_win;
                end
                ARB: begin
                    r_ptr <= r_idx;
                    r_cnt <= w_len;
                    r_cfg <= w_cfgs[r_idx];
                    r_err <= 1'b0;
                    if (w_len != '0) r_cs_n <= ~r_grant;
                end
                FETCH: if (w_accept) begin
                    r_tx       <= i_wdata;
                    r_tx_valid <= 1'b1;
                end
                SEND: if (!i_spi_ready || w_tmo) r_tx_valid <= 1'b0;
                RECV: if (i_spi_rx_valid) begin
                    r_rdata  <= i_spi_rx;
                    r_rvalid <= 1'b1;
                    r_cnt    <= r_cnt - 1'b1;
                end
                HOLD: if (w_next == DONE) r_cs_n <= '1;
                DONE: r_grant <= '0;
                default: ;
            endcase
            if (w_tmo) r_err <= 1'b1;
        end
    end

    assign o_grant        = r_grant;
    assign o_wready       = r_wready;
    assign o_rdata        = r_rdata;
    assign o_rvalid       = r_rvalid;
    assign o_done         = (r_state == DONE);
    assign o_err          = (r_state == DONE) && r_err;
    assign o_cs_n         = r_cs_n;
    assign o_spi_config   = r_cfg;
    assign o_spi_tx       = r_tx;
    assign o_spi_tx_valid = r_tx_valid;
endmodule

// File: tb/tb_spi_bus_scheduler.sv
// tb_spi_bus_scheduler: scoreboard bench with loopback SPI model and a queued requester
module tb_spi_bus_scheduler;
    localparam int N = 4, LW = 8, CS_SETUP = 4, CS_HOLD = 4, TIMEOUT = 1024;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] len = '0;
    logic [N*11-1:0] cfg = '0;
    logic [N-1:0]    grant, cs_n;
    logic [7:0]      wdata = 8'h00, rdata, spi_tx, spi_rx = 8'h00;
    logic            wvalid = 1'b0, wready, rvalid, done, err, spi_tx_valid;
    logic            spi_rx_valid = 1'b0, spi_ready = 1'b1;
    logic [10:0]     spi_config;

    spi_bus_scheduler #(.NUM_REQ(N), .LEN_W(LW), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_len(len), .i_cfg(cfg), .o_grant(grant),
        .i_wdata(wdata), .i_wvalid(wvalid), .o_wready(wready), .o_rdata(rdata), .o_rvalid(rvalid),
        .o_done(done), .o_err(err), .o_cs_n(cs_n), .o_spi_config(spi_config), .o_spi_tx(spi_tx),
        .o_spi_tx_valid(spi_tx_valid), .i_spi_rx(spi_rx), .i_spi_rx_valid(spi_rx_valid), .i_spi_ready(spi_ready)
    );

    int n_cmp = 0, n_fail = 0;
    logic [7:0]   wq[$], exp_q[$];
    logic [N-1:0] gq[$];
    logic [10:0]  cq[$];
    logic [N-1:0] g_watch = '0, cs_prev = '1;
    int cyc = 0, n_done, n_err, n_rv, n_wr, n_txv, n_g, t_cs, t_tx, t_rv, t_csh;
    bit stuck = 1'b0;

    // Loopback SPI controller: ready drops two cycles after tx_valid, rx returns the tx byte.
    initial begin
        int phase, cnt;
        logic [7:0] lat;
        phase = 0; cnt = 0; lat = 8'h00;
        forever begin
            @(negedge clk);
            spi_rx_valid = 1'b0;
            if (!rst_n) begin
                phase = 0; spi_ready = 1'b1;
            end else if (stuck) spi_ready = 1'b1;
            else case (phase)
                0: if (spi_tx_valid) begin lat = spi_tx; phase = 1; cnt = 0; end
                1: begin cnt++; if (cnt == 2) begin spi_ready = 1'b0; phase = 2; cnt = 0; end end
                2: begin cnt++; if (cnt == 4) begin spi_rx = lat; spi_rx_valid = 1'b1; phase = 3; end end
                default: begin spi_ready = 1'b1; phase = 0; end
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) wq.delete();
            else if (wready && wq.size() > 0) void'(wq.pop_front());
            wvalid = rst_n && (wq.size() > 0);
            wdata  = (wq.size() > 0) ? wq[0] : 8'h00;
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (done) begin n_done++; gq.push_back(grant); cq.push_back(spi_config); end
            if (err) n_err++;
            n_cmp++;
            if (err && !done) begin n_fail++; $display("FAIL err_alone: err=%b done=%b, required err only with done", err, done); end
            n_cmp++;
            if ($countones(~cs_n) > 1) begin n_fail++; $display("FAIL cs_multi_low: cs_n=%b, required at most one low", cs_n); end
            if (wready) n_wr++;
            if (spi_tx_valid) begin n_txv++; if (t_tx < 0) t_tx = cyc; end
            if (grant == g_watch) n_g++;
            if (rvalid) begin
                n_rv++; t_rv = cyc; n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rdata_unexpected: got %h, required no rvalid", rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e || grant == '0) begin
                        n_fail++; $display("FAIL rdata: got %h grant=%b, required %h with grant", rdata, grant, e);
                    end
                end
            end
            if (cs_prev == '1 && cs_n != '1) t_cs = cyc;
            if (cs_prev != '1 && cs_n == '1) t_csh = cyc;
            cs_prev = cs_n;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic clr_stats();
        n_done = 0; n_err = 0; n_rv = 0; n_wr = 0; n_txv = 0; n_g = 0;
        t_cs = -1; t_tx = -1; t_rv = -1; t_csh = -1;
        gq.delete(); cq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; stuck = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_grant(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (grant != '0) return;
        end
        n_cmp++; n_fail++;
        $display("FAIL grant_timeout: no grant within %0d cycles, required grant", bound);
    endtask

    task automatic wait_done(input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (done) return;
        end
        n_cmp++; n_fail++;
        $display("FAIL done_timeout: no o_done within %0d cycles, required o_done", bound);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (cs_n !== 4'hF) begin n_fail++; $display("FAIL rst_cs_n: got %b, required 1111", cs_n); end
        n_cmp++; if (grant !== 4'h0) begin n_fail++; $display("FAIL rst_grant: got %b, required 0000", grant); end
        n_cmp++; if (spi_config !== 11'h0) begin n_fail++; $display("FAIL rst_config: got %h, required 000", spi_config); end
        n_cmp++; if (spi_tx !== 8'h00) begin n_fail++; $display("FAIL rst_spi_tx: got %h, required 00", spi_tx); end
        n_cmp++;
        if ({wready, rvalid, done, err, spi_tx_valid} !== 5'b0) begin
            n_fail++; $display("FAIL rst_pulses: got %b, required 00000", {wready, rvalid, done, err, spi_tx_valid});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        clr_stats();
        len[0 +: LW] = 8'd2; cfg[0 +: 11] = 11'h155;
        wq.push_back(8'hA5); wq.push_back(8'h3C);
        exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
        req = 4'b0001;
        wait_grant(20); req = '0;
        wait_done(300);
        @(negedge clk);
        n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL single_done: got %0d, required 1", n_done); end
        n_cmp++; if (n_err !== 0) begin n_fail++; $display("FAIL single_err: got %0d, required 0", n_err); end
        n_cmp++; if (n_wr !== 2) begin n_fail++; $display("FAIL single_wready: got %0d, required 2", n_wr); end
        n_cmp++; if (n_rv !== 2) begin n_fail++; $display("FAIL single_rvalid: got %0d, required 2", n_rv); end
        n_cmp++; if (t_tx - t_cs !== CS_SETUP) begin n_fail++; $display("FAIL single_setup: got %0d, required %0d", t_tx - t_cs, CS_SETUP); end
        n_cmp++; if (t_csh - t_rv !== CS_HOLD) begin n_fail++; $display("FAIL single_hold: got %0d, required %0d", t_csh - t_rv, CS_HOLD); end
        n_cmp++; if (spi_config !== 11'h155) begin n_fail++; $display("FAIL single_config: got %h, required 155", spi_config); end
        n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL single_pending: got %0d, required 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        do_reset();
        clr_stats();
        for (int k = 0; k < N; k++) begin
            len[k*LW +: LW] = 8'd1; cfg[k*11 +: 11] = 11'h100 + 11'(k);
            wq.push_back(8'h10 + 8'(k)); exp_q.push_back(8'h10 + 8'(k));
        end
        wq.push_back(8'h20); exp_q.push_back(8'h20);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_done(300);
        req = '0;
        @(negedge clk);
        n_cmp++; if (gq.size() !== 5) begin n_fail++; $display("FAIL rr_count: got %0d, required 5", gq.size()); end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (gq[k] !== 4'(1 << (k % N)) || cq[k] !== 11'h100 + 11'(k % N)) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got grant %b cfg %h, required %b %h", k, gq[k], cq[k], 4'(1 << (k % N)), 11'h100 + 11'(k % N));
            end
        end
        n_cmp++; if (n_rv !== 5 || n_err !== 0) begin n_fail++; $display("FAIL rr_data: got rvalid %0d err %0d, required 5 0", n_rv, n_err); end
    endtask

    task automatic test_zero_len();
        clr_stats();
        len[1*LW +: LW] = 8'd0; cfg[1*11 +: 11] = 11'h2AA;
        g_watch = 4'b0010;
        req = 4'b0010;
        wait_grant(20); req = '0;
        wait_done(20);
        @(negedge clk);
        n_cmp++; if (n_g !== 2) begin n_fail++; $display("FAIL zero_grant_cycles: got %0d, required 2", n_g); end
        n_cmp++; if (n_done !== 1 || n_err !== 0) begin n_fail++; $display("FAIL zero_done: got done %0d err %0d, required 1 0", n_done, n_err); end
        n_cmp++; if (t_cs !== -1) begin n_fail++; $display("FAIL zero_cs: got cs low at %0d, required never", t_cs); end
        n_cmp++; if (n_txv !== 0) begin n_fail++; $display("FAIL zero_txv: got %0d, required 0", n_txv); end
        n_cmp++; if (spi_config !== 11'h2AA) begin n_fail++; $display("FAIL zero_config: got %h, required 2AA", spi_config); end
        g_watch = '0;
    endtask

    task automatic test_timeout();
        clr_stats();
        stuck = 1'b1;
        len[0 +: LW] = 8'd1;
        wq.push_back(8'h5A);
        req = 4'b0001;
        wait_grant(20); req = '0;
        wait_done(TIMEOUT + 200);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err_with_done: got %b, required 1", err); end
        @(negedge clk);
        n_cmp++; if (n_done !== 1 || n_err !== 1) begin n_fail++; $display("FAIL tmo_counts: got done %0d err %0d, required 1 1", n_done, n_err); end
        n_cmp++; if (n_txv !== TIMEOUT) begin n_fail++; $display("FAIL tmo_txv_cycles: got %0d, required %0d", n_txv, TIMEOUT); end
        n_cmp++; if (n_rv !== 0 || cs_n !== 4'hF) begin n_fail++; $display("FAIL tmo_state: got rvalid %0d cs_n %b, required 0 1111", n_rv, cs_n); end
        stuck = 1'b0;
        clr_stats();
        len[2*LW +: LW] = 8'd1;
        wq.push_back(8'h77); exp_q.push_back(8'h77);
        req = 4'b0100;
        wait_grant(20); req = '0;
        wait_done(300);
        @(negedge clk);
        n_cmp++; if (n_rv !== 1 || n_err !== 0) begin n_fail++; $display("FAIL tmo_recover: got rvalid %0d err %0d, required 1 0", n_rv, n_err); end
        n_cmp++; if (gq.size() !== 1 || gq[0] !== 4'b0100) begin n_fail++; $display("FAIL tmo_recover_grant: got %b, required 0100", gq[0]); end
    endtask

    task automatic test_wvalid_gap();
        int k;
        clr_stats();
        len[3*LW +: LW] = 8'd3;
        wq.push_back(8'hC1);
        exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
        req = 4'b1000;
        wait_grant(20); req = '0;
        k = 0;
        while (n_rv < 1 && k < 200) begin @(negedge clk); k++; end
        repeat (50) @(negedge clk);
        n_cmp++; if (cs_n !== 4'b0111) begin n_fail++; $display("FAIL gap_cs: got %b, required 0111", cs_n); end
        n_cmp++; if (n_rv !== 1 || n_err !== 0 || n_done !== 0) begin n_fail++; $display("FAIL gap_wait: got rvalid %0d err %0d done %0d, required 1 0 0", n_rv, n_err, n_done); end
        wq.push_back(8'hC2); wq.push_back(8'hC3);
        wait_done(300);
        @(negedge clk);
        n_cmp++; if (n_rv !== 3 || n_err !== 0 || n_done !== 1) begin n_fail++; $display("FAIL gap_done: got rvalid %0d err %0d done %0d, required 3 0 1", n_rv, n_err, n_done); end
    endtask

    task automatic test_reset_mid();
        int k;
        clr_stats();
        len[0 +: LW] = 8'd4;
        wq.push_back(8'hD1); wq.push_back(8'hD2); wq.push_back(8'hD3); wq.push_back(8'hD4);
        exp_q.push_back(8'hD1);
        req = 4'b0001;
        wait_grant(20); req = '0;
        k = 0;
        while (n_wr < 2 && k < 200) begin @(negedge clk); k++; end
        k = 0;
        while (spi_tx_valid && k < 50) begin @(negedge clk); k++; end
        n_cmp++; if (n_rv !== 1 || cs_n !== 4'b1110) begin n_fail++; $display("FAIL mid_pre: got rvalid %0d cs_n %b, required 1 1110", n_rv, cs_n); end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (cs_n !== 4'hF || grant !== 4'h0) begin n_fail++; $display("FAIL mid_reset: got cs_n %b grant %b, required 1111 0000", cs_n, grant); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (n_done !== 0 || exp_q.size() !== 0) begin n_fail++; $display("FAIL mid_no_done: got done %0d pending %0d, required 0 0", n_done, exp_q.size()); end
        clr_stats();
        len[1*LW +: LW] = 8'd2;
        wq.push_back(8'h11); wq.push_back(8'h22);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        req = 4'b0010;
        wait_grant(20); req = '0;
        wait_done(300);
        @(negedge clk);
        n_cmp++; if (n_rv !== 2 || n_err !== 0 || gq[0] !== 4'b0010) begin n_fail++; $display("FAIL mid_after: got rvalid %0d err %0d grant %b, required 2 0 0010", n_rv, n_err, gq[0]); end
        n_cmp++; if (t_tx - t_cs !== CS_SETUP) begin n_fail++; $display("FAIL mid_after_setup: got %0d, required %0d", t_tx - t_cs, CS_SETUP); end
    endtask

    initial begin
        clr_stats();
        test_reset();
        test_single();
        test_round_robin();
        test_zero_len();
        test_timeout();
        test_wvalid_gap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
